fifo_ptr_ctrl: RTL and testbench

Upstream pointer stage of the FIFO control path. Turns write/read requests into accepted-transfer strobes and registered write/read addresses. The addresses feed the RAM and the downstream full/empty flag controller. Keeps an occupancy count and a 3-state fill FSM so illegal transfers are never accepted, and records overflow/underflow attempts in sticky error flags.

---
 rtl/fifo_ptr_ctrl.sv | 139 +++++++++++++
 tb/tb_fifo_ptr_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: upstream pointer stage of the FIFO control path.
// Converts level write/read requests into same-cycle accept strobes,
// advances registered write/read pointers, tracks occupancy with a
// 3-state fill FSM and keeps sticky overflow/underflow flags.
// Optional feature macro: FIFO_ALMOST_FLAGS_EN (registered almost-full /
// almost-empty flags; without it o_afull/o_aempty are tied to 0).
module fifo_ptr_ctrl #(
    parameter int DEPTH_BIT = 4,
    parameter int DEPTH_MAX = (1 << DEPTH_BIT) - 1
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2
`endif
) (
    input  logic                 i_clk,
    input  logic                 i_rest,
    input  logic                 i_wr_req,
    input  logic                 i_rd_req,
    input  logic                 i_err_clr,
    output logic [DEPTH_BIT-1:0] o_addrw,
    output logic [DEPTH_BIT-1:0] o_addrr,
    output logic                 o_wr_ack,
    output logic                 o_rd_ack,
    output logic [DEPTH_BIT-1:0] o_count,
    output logic [1:0]           o_state,
    output logic                 o_ovf,
    output logic                 o_udf,
    output logic                 o_afull,
    output logic                 o_aempty
);

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_PART  = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b10;
    localparam logic [1:0] ST_BAD   = 2'b11;

    localparam logic [DEPTH_BIT-1:0] CNT_MAX = DEPTH_BIT'(DEPTH_MAX);
    localparam logic [DEPTH_BIT-1:0] ONE     = DEPTH_BIT'(1);
    localparam logic [DEPTH_BIT-1:0] ZERO    = '0;

    logic [DEPTH_BIT-1:0] addrw_q, addrw_d;
    logic [DEPTH_BIT-1:0] addrr_q, addrr_d;
    logic [DEPTH_BIT-1:0] count_q, count_d;
    logic [1:0]           state_q, state_d;
    logic                 ovf_q, ovf_d;
    logic                 udf_q, udf_d;
    logic                 wr_ok, rd_ok;

    // Acceptance from pre-edge state only; the illegal state accepts nothing.
    always_comb begin
        wr_ok = i_wr_req & ~i_rest & ((state_q == ST_EMPTY) | (state_q == ST_PART));
        rd_ok = i_rd_req & ~i_rest & ((state_q == ST_PART)  | (state_q == ST_FULL));
    end

    // Next pointers, occupancy and fill state; state is derived from next count.
    always_comb begin
        addrw_d = addrw_q;
        addrr_d = addrr_q;
        count_d = count_q;
        state_d = state_q;
        if (wr_ok) addrw_d = addrw_q + ONE;
        if (rd_ok) addrr_d = addrr_q + ONE;
        if (wr_ok & ~rd_ok)      count_d = count_q + ONE;
        else if (rd_ok & ~wr_ok) count_d = count_q - ONE;

        if (state_q == ST_BAD) begin
            // Recover to a consistent empty FIFO: read pointer catches up.
            count_d = ZERO;
            addrr_d = addrw_q;
            state_d = ST_EMPTY;
        end else if (count_d == ZERO) begin
            state_d = ST_EMPTY;
        end else if (count_d == CNT_MAX) begin
            state_d = ST_FULL;
        end else begin
            state_d = ST_PART;
        end
    end

    // Sticky errors: a set event in the same cycle beats the clear.
    always_comb begin
        ovf_d = (i_wr_req & (state_q == ST_FULL))  | (ovf_q & ~i_err_clr);
        udf_d = (i_rd_req & (state_q == ST_EMPTY)) | (udf_q & ~i_err_clr);
    end

    // Register update; reset discards all occupancy without draining.
    always_ff @(posedge i_clk) begin
        if (i_rest) begin
            addrw_q <= '0;
            addrr_q <= '0;
            count_q <= '0;
            state_q <= ST_EMPTY;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            addrw_q <= addrw_d;
            addrr_q <= addrr_d;
            count_q <= count_d;
            state_q <= state_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

`ifdef FIFO_ALMOST_FLAGS_EN
    localparam logic [DEPTH_BIT-1:0] AF_TH = DEPTH_BIT'(AFULL_TH);
    localparam logic [DEPTH_BIT-1:0] AE_TH = DEPTH_BIT'(AEMPTY_TH);

    logic afull_q, aempty_q;

    // Almost flags track next count so they move on the same edge as o_count.
    always_ff @(posedge i_clk) begin
        if (i_rest) begin
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            afull_q  <= (count_d >= AF_TH);
            aempty_q <= (count_d <= AE_TH);
        end
    end

    assign o_afull  = afull_q;
    assign o_aempty = aempty_q;
`else
    assign o_afull  = 1'b0;
    assign o_aempty = 1'b0;
`endif

    assign o_addrw  = addrw_q;
    assign o_addrr  = addrr_q;
    assign o_count  = count_q;
    assign o_state  = state_q;
    assign o_ovf    = ovf_q;
    assign o_udf    = udf_q;
    assign o_wr_ack = wr_ok;
    assign o_rd_ack = rd_ok;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Scoreboard bench for fifo_ptr_ctrl: the driver applies directed and random
// request patterns, a counting reference model predicts every cycle's
// outputs into a queue, and an independent monitor pops and compares.
module tb_fifo_ptr_ctrl;

    localparam int DB   = 4;
    localparam int NPTR = 1 << DB;
    localparam int CAP  = NPTR - 1;

    logic          clk;
    logic          rst, wr, rd, clr;
    logic [DB-1:0] addrw, addrr, count;
    logic          wr_ack, rd_ack;
    logic [1:0]    state;
    logic          ovf, udf, afull, aempty;

    fifo_ptr_ctrl dut (
        .i_clk(clk), .i_rest(rst), .i_wr_req(wr), .i_rd_req(rd), .i_err_clr(clr),
        .o_addrw(addrw), .o_addrr(addrr), .o_wr_ack(wr_ack), .o_rd_ack(rd_ack),
        .o_count(count), .o_state(state), .o_ovf(ovf), .o_udf(udf),
        .o_afull(afull), .o_aempty(aempty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int wa, ra, aw, ar, cnt, st, ov, ud, af, ae;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   drv_done = 0;

    // Reference model: plain occupancy arithmetic on integers.
    int m_occ = 0, m_w = 0, m_r = 0, m_ov = 0, m_ud = 0;

    function automatic int st_of(int occ);
        return (occ == 0) ? 0 : (occ == CAP) ? 2 : 1;
    endfunction

    task automatic cyc(input bit r, input bit w, input bit d, input bit c, input bit push = 1);
        exp_t e;
        int   wok, rok;
        @(negedge clk);
        rst = r; wr = w; rd = d; clr = c;
        wok = (w && !r && m_occ != CAP) ? 1 : 0;
        rok = (d && !r && m_occ != 0) ? 1 : 0;
        e.wa = wok; e.ra = rok;
        e.aw = m_w; e.ar = m_r; e.cnt = m_occ; e.st = st_of(m_occ);
        e.ov = m_ov; e.ud = m_ud;
`ifdef FIFO_ALMOST_FLAGS_EN
        e.af = (m_occ >= 12) ? 1 : 0;
        e.ae = (m_occ <= 2) ? 1 : 0;
`else
        e.af = 0; e.ae = 0;
`endif
        if (push) exp_q.push_back(e);
        if (r) begin
            m_occ = 0; m_w = 0; m_r = 0; m_ov = 0; m_ud = 0;
        end else begin
            m_ov = ((w && m_occ == CAP) || (m_ov && !c)) ? 1 : 0;
            m_ud = ((d && m_occ == 0) || (m_ud && !c)) ? 1 : 0;
            m_w = (m_w + wok) % NPTR;
            m_r = (m_r + rok) % NPTR;
            m_occ = m_occ + wok - rok;
        end
    endtask

    task automatic chk(input string name, input int act, input int expv);
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: every cycle the DUT presents a full output set; compare it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                chk("wr_ack", int'(wr_ack), e.wa);
                chk("rd_ack", int'(rd_ack), e.ra);
                chk("addrw",  int'(addrw),  e.aw);
                chk("addrr",  int'(addrr),  e.ar);
                chk("count",  int'(count),  e.cnt);
                chk("state",  int'(state),  e.st);
                chk("ovf",    int'(ovf),    e.ov);
                chk("udf",    int'(udf),    e.ud);
                chk("afull",  int'(afull),  e.af);
                chk("aempty", int'(aempty), e.ae);
                chk("ptr_diff", (int'(addrw) - int'(addrr) + NPTR) % NPTR, int'(count));
            end
        end
    end

    // Driver: directed test-plan sequences followed by random traffic.
    initial begin
        rst = 1'b1; wr = 1'b0; rd = 1'b0; clr = 1'b0;
        cyc(1, 0, 0, 0, 0);               // registers unknown before first edge
        cyc(1, 0, 0, 0);                  // reset state visible
        for (int i = 0; i < 15; i++) cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);                  // write while full -> no ack, ovf
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);                  // clear ovf
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 1, 1, 0);  // streaming, pointers wrap
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 1, 0);                  // both in EMPTY: write only, udf
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);                  // set event beats clear? none here, clears udf
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 15; i++) cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 1);                  // both in FULL: read only, ovf set beats clear
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);                  // reset beats write at count 10
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias = (i / 200) % 3;         // phases lean toward fill, drain, balanced
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 9) < (bias == 0 ? 7 : bias == 1 ? 3 : 5)),
                ($urandom_range(0, 9) < (bias == 0 ? 3 : bias == 1 ? 7 : 5)),
                ($urandom_range(0, 15) == 0));
        end
        cyc(0, 0, 0, 0);
        drv_done = 1;
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        if (vectors < 12) begin
            miscompares++;
            $display("FAIL vector_count: got %0d, required at least 12", vectors);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #1000000;
        $display("FAIL timeout: simulation time limit reached, driver_done=%0d", drv_done);
        $fatal(1, "timeout");
    end

endmodule
